// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues word loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_MEM_valid,
  input  logic        i_MEM_ctrl_MemRead,
  input  logic        i_MEM_ctrl_MemWrite,
  input  logic        i_MEM_ctrl_Mem2Reg,
  input  logic        i_MEM_ctrl_RegWrite,
  input  logic [31:0] i_MEM_data_RegAddrW,
  input  logic [31:0] i_MEM_data_ALUData,
  input  logic [31:0] i_MEM_data_StoreData,
  output logic        o_MEM_dmem_Req,
  output logic        o_MEM_dmem_We,
  output logic [31:0] o_MEM_dmem_Addr,
  output logic [31:0] o_MEM_dmem_WData,
  input  logic        i_MEM_dmem_Ack,
  input  logic [31:0] i_MEM_dmem_RData,
  output logic        o_MEM_stall,
  output logic        o_MEM_ctrl_Mem2Reg,
  output logic        o_MEM_ctrl_RegWrite,
  output logic [31:0] o_MEM_data_RegAddrW,
  output logic [31:0] o_MEM_data_MemData,
  output logic [31:0] o_MEM_data_ALUData,
  output logic        o_MEM_exc_Misalign,
  output logic        o_MEM_exc_Timeout,
  output logic        o_MEM_dbg_wait
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Handshake: Req stays high with stable We/Addr/WData until the cycle
  // in which Ack is seen (transfer) or the access is aborted on timeout.
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic w_memop;
  logic w_misalign;
  logic w_access;
  logic w_abort;
  logic w_stall;

  logic        r_mem2reg;
  logic        r_regwrite;
  logic [31:0] r_regaddrw;
  logic [31:0] r_memdata;
  logic [31:0] r_aludata;
  logic        r_exc_misalign;
  logic        r_exc_timeout;

  assign w_memop    = i_MEM_valid & (i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite);
  assign w_misalign = w_memop & (i_MEM_data_ALUData[1:0] != 2'b00);
  assign w_access   = w_memop & ~w_misalign;
  // The first WAIT cycle sees cnt = 0, so Req is held for TIMEOUT+1 cycles before the abort cycle.
  assign w_abort    = (r_state == S_WAIT) & (r_cnt == CW'(TIMEOUT)) & ~i_MEM_dmem_Ack;
  assign w_stall    = w_access & ~i_MEM_dmem_Ack & ~w_abort;

  assign o_MEM_dmem_Req   = w_access & ~w_abort;
  assign o_MEM_dmem_We    = i_MEM_ctrl_MemWrite;
  assign o_MEM_dmem_Addr  = i_MEM_data_ALUData;
  assign o_MEM_dmem_WData = i_MEM_data_StoreData;
  assign o_MEM_stall      = w_stall;
  assign o_MEM_dbg_wait   = (r_state == S_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_access & ~i_MEM_dmem_Ack) w_state_nxt = S_WAIT;
      S_WAIT:  if (i_MEM_dmem_Ack | w_abort)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) r_cnt <= r_cnt + CW'(1);
      else                                                 r_cnt <= '0;
    end
  end

  // A stalled cycle inserts a bubble into MEM/WB; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem2reg      <= 1'b0;
      r_regwrite     <= 1'b0;
      r_regaddrw     <= '0;
      r_memdata      <= '0;
      r_aludata      <= '0;
      r_exc_misalign <= 1'b0;
      r_exc_timeout  <= 1'b0;
    end else if (w_stall) begin
      r_regwrite     <= 1'b0;
      r_exc_misalign <= 1'b0;
      r_exc_timeout  <= 1'b0;
    end else begin
      r_mem2reg      <= i_MEM_ctrl_Mem2Reg;
      r_regwrite     <= i_MEM_valid & i_MEM_ctrl_RegWrite & ~w_misalign & ~w_abort;
      r_regaddrw     <= i_MEM_data_RegAddrW;
      r_memdata      <= (w_access & i_MEM_ctrl_MemRead & i_MEM_dmem_Ack) ? i_MEM_dmem_RData : 32'h0;
      r_aludata      <= i_MEM_data_ALUData;
      r_exc_misalign <= w_misalign;
      r_exc_timeout  <= w_abort;
    end
  end

  assign o_MEM_ctrl_Mem2Reg  = r_mem2reg;
  assign o_MEM_ctrl_RegWrite = r_regwrite;
  assign o_MEM_data_RegAddrW = r_regaddrw;
  assign o_MEM_data_MemData  = r_memdata;
  assign o_MEM_data_ALUData  = r_aludata;
  assign o_MEM_exc_Misalign  = r_exc_misalign;
  assign o_MEM_exc_Timeout   = r_exc_timeout;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a driver issues instructions against a latency-based memory
// model, and a monitor pops expected MEM/WB contents whenever the stage advances.
module tb_mem_stage;

  localparam int T = 4;
  localparam int W = 100;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_rd, i_wr, i_m2r, i_rw;
  logic [31:0] i_rad, i_alu, i_sd;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        o_req, o_we;
  logic [31:0] o_addr, o_wdata;
  logic        o_stall;
  logic        o_m2r, o_rw;
  logic [31:0] o_rad, o_md, o_alu;
  logic        o_mis, o_to, o_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  bit armed = 1'b0;

  mem_stage #(.TIMEOUT(T)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_MEM_valid          (i_valid),
    .i_MEM_ctrl_MemRead   (i_rd),
    .i_MEM_ctrl_MemWrite  (i_wr),
    .i_MEM_ctrl_Mem2Reg   (i_m2r),
    .i_MEM_ctrl_RegWrite  (i_rw),
    .i_MEM_data_RegAddrW  (i_rad),
    .i_MEM_data_ALUData   (i_alu),
    .i_MEM_data_StoreData (i_sd),
    .o_MEM_dmem_Req       (o_req),
    .o_MEM_dmem_We        (o_we),
    .o_MEM_dmem_Addr      (o_addr),
    .o_MEM_dmem_WData     (o_wdata),
    .i_MEM_dmem_Ack       (i_ack),
    .i_MEM_dmem_RData     (i_rdata),
    .o_MEM_stall          (o_stall),
    .o_MEM_ctrl_Mem2Reg   (o_m2r),
    .o_MEM_ctrl_RegWrite  (o_rw),
    .o_MEM_data_RegAddrW  (o_rad),
    .o_MEM_data_MemData   (o_md),
    .o_MEM_data_ALUData   (o_alu),
    .o_MEM_exc_Misalign   (o_mis),
    .o_MEM_exc_Timeout    (o_to),
    .o_MEM_dbg_wait       (o_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_rw"},  o_rw,  0);
    check({tag, "_m2r"}, o_m2r, 0);
    check({tag, "_rad"}, o_rad, 0);
    check({tag, "_md"},  o_md,  0);
    check({tag, "_alu"}, o_alu, 0);
    check({tag, "_exc"}, {o_mis, o_to}, 0);
    check({tag, "_dbg"}, o_dbg, 0);
  endtask

  task automatic drive_idle();
    i_valid = 0; i_rd = 0; i_wr = 0; i_m2r = 0; i_rw = 0;
    i_rad = 0; i_alu = 0; i_sd = 0; i_ack = 0; i_rdata = 0;
  endtask

  // Driver: lat = cycle (0 = request cycle) in which memory acks; NEVER = no ack.
  task automatic issue(input bit v, input bit rd, input bit wr, input bit m2r, input bit rw,
                       input logic [31:0] rad, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] rdata, input int lat);
    bit memop, mis, acc, ok, tmo, rw_exp, done;
    logic [31:0] md;
    int reqs, stalls, c, exp_reqs, exp_stalls;
    memop  = v && (rd || wr);
    mis    = memop && (alu[1:0] != 2'b00);
    acc    = memop && !mis;
    ok     = !acc || (lat <= T + 1);
    tmo    = acc && !ok;
    rw_exp = v && rw && !mis && !tmo;
    md     = (acc && rd && ok) ? rdata : 32'h0;
    exp_reqs   = !acc ? 0 : (ok ? lat + 1 : T + 1);
    exp_stalls = !acc ? 0 : (ok ? lat : T + 1);
    @(posedge clk); #1;
    i_valid = v; i_rd = rd; i_wr = wr; i_m2r = m2r; i_rw = rw;
    i_rad = rad; i_alu = alu; i_sd = sd; i_rdata = rdata;
    reqs = 0; stalls = 0; c = 0; done = 0;
    while (!done) begin
      i_ack = acc ? (c == lat) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) check("idle_at_issue", o_dbg, 0);
      if (o_req) begin
        reqs++;
        check("req_we", o_we, wr);
        check("req_addr", o_addr, alu);
        check("req_wdata", o_wdata, sd);
      end
      if (o_stall) stalls++;
      else begin
        done = 1;
        exp_q.push_back({rw_exp, m2r, mis, tmo, rad, md, alu});
      end
      if (!done) begin
        if (c > T + 3) begin
          total++; bad++;
          $display("FAIL stall_bound: stall still high after %0d cycles", c);
          done = 1;
        end else begin
          @(posedge clk); #1;
          c++;
        end
      end
    end
    check("req_cycles", reqs, exp_reqs);
    check("stall_cycles", stalls, exp_stalls);
  endtask

  // Monitor / scoreboard: every non-stalled edge while armed retires one entry.
  initial begin
    bit pending, prev_stall;
    logic [W-1:0] e;
    pending = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: stage advanced with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("wb_regwrite", o_rw,  e[99]);
          check("wb_mem2reg",  o_m2r, e[98]);
          check("wb_misalign", o_mis, e[97]);
          check("wb_timeout",  o_to,  e[96]);
          check("wb_regaddrw", o_rad, e[95:64]);
          check("wb_memdata",  o_md,  e[63:32]);
          check("wb_aludata",  o_alu, e[31:0]);
        end
      end else if (prev_stall) begin
        check("bubble_regwrite", o_rw, 0);
        check("bubble_exc", {o_mis, o_to}, 0);
      end
      pending    = armed && !rst && !o_stall;
      prev_stall = armed && !rst && o_stall;
    end
  end

  initial begin
    int kind, lat;
    logic [31:0] a;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_wb_zero("rst");
    check("rst_req", o_req, 0);
    check("rst_stall", o_stall, 0);

    // reset asserted while an access is outstanding
    @(posedge clk); #1;
    i_valid = 1; i_rd = 1; i_rw = 1; i_alu = 32'h40; i_rad = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midwait_state", o_dbg, 1);
    check("midwait_stall", o_stall, 1);
    rst = 1'b1;
    #1 drive_idle();
    check("midwait_async", o_dbg, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_wb_zero("rst2");
    check("rst2_req", o_req, 0);
    check("rst2_stall", o_stall, 0);

    // directed cases, then random traffic
    armed = 1'b1;
    issue(1, 1, 0, 1, 1, 32'd8,  32'h100, 32'h0,        32'hDEADBEEF, 0);
    issue(1, 0, 1, 0, 0, 32'd0,  32'h200, 32'h12345678, 32'h0,        2);
    issue(1, 1, 0, 1, 1, 32'd9,  32'h102, 32'h0,        32'h55AA55AA, 0);
    issue(1, 1, 0, 1, 1, 32'd10, 32'h300, 32'h0,        32'h0BADF00D, NEVER);
    issue(1, 0, 0, 0, 1, 32'd11, 32'h7,   32'h0,        32'hFFFFFFFF, 0);
    issue(1, 1, 0, 1, 1, 32'd12, 32'h304, 32'h0,        32'hCAFEF00D, T + 1);
    issue(1, 0, 1, 0, 0, 32'd13, 32'h3,   32'hAAAA5555, 32'h0,        0);
    issue(0, 1, 0, 1, 1, 32'd14, 32'h400, 32'h0,        32'h1,        0);
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 4);
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      lat = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, T + 1);
      case (kind)
        0:       issue(0, 1'($urandom), 0, 1'($urandom), 1'($urandom), $urandom, a, $urandom, $urandom, lat);
        1:       issue(1, 0, 0, 0, 1'($urandom), $urandom, a, $urandom, $urandom, lat);
        3:       issue(1, 0, 1, 0, 1'($urandom), $urandom, a, $urandom, $urandom, lat);
        default: issue(1, 1, 0, 1, 1'($urandom), $urandom, a, $urandom, $urandom, lat);
      endcase
    end
    @(posedge clk); #1;
    armed = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("final_state", o_dbg, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
